// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory responder.
// One-hot FSM encoding, NOP filler word, latency counter width.
package inst_mem_pkg;

    localparam int LAT_W = 4;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_WAIT = 3'b010,
        S_RESP = 3'b100
    } state_e;

    localparam int IDLE_B = 0;
    localparam int WAIT_B = 1;
    localparam int RESP_B = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } resp_t;

    // Misaligned, or outside the 2^aw-word array.
    function automatic logic pc_bad(
        input logic [31:0] pc,
        input int          aw
    );
        return (pc[1:0] != 2'b00) ||
               ((pc >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/inst_ram_sync.sv
// Single-clock instruction RAM: one write port,
// one registered read port (read-first).
module inst_ram_sync #(
  parameter int AW        = 10,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Responder side of the fetch request/response handshake with a
// configurable-latency instruction memory and a side-band load port.
//   PC/Inst_Req_Valid/Inst_Req_Ready : request handshake
//   Instruction/Inst_Fault/Inst_Valid/Inst_Ready : response handshake
//   Load_En/Load_Addr/Load_Data : program image write port
module inst_mem_responder
    import inst_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           PC,
    input  logic                  Inst_Req_Valid,
    output logic                  Inst_Req_Ready,
    output logic [31:0]           Instruction,
    output logic                  Inst_Valid,
    input  logic                  Inst_Ready,
    output logic                  Inst_Fault,
    input  logic                  Load_En,
    input  logic [ADDR_WIDTH-1:0] Load_Addr,
    input  logic [31:0]           Load_Data
);

    localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);

    state_e                state_d, state_q;
    logic [LAT_W-1:0]      cnt_d, cnt_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic                  bad_d, bad_q;
    resp_t                 resp_d, resp_q;
    logic                  fwd_hit_d, fwd_hit_q;
    logic [31:0]           fwd_data_d, fwd_data_q;

    logic                  req_ready;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] pc_word;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [31:0]           ram_rdata;
    logic [31:0]           ram_word;

    assign pc_word   = PC[ADDR_WIDTH+1:2];
    assign req_ready = state_q[IDLE_B] && !Load_En;
    assign accept    = Inst_Req_Valid && req_ready;

    // Read from PC while idle so data is already
    // registered one edge after acceptance.
    assign rd_addr = state_q[IDLE_B] ? pc_word : addr_q;

    inst_ram_sync #(
        .AW       (ADDR_WIDTH),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .we   (Load_En),
        .waddr(Load_Addr),
        .wdata(Load_Data),
        .raddr(rd_addr),
        .rdata(ram_rdata)
    );

    // The registered read lags a write by one edge;
    // forward a load hit from the previous edge so
    // only a same-edge load is read-first.
    always_comb begin
        fwd_hit_d  = Load_En && (Load_Addr == rd_addr);
        fwd_data_d = Load_Data;
    end

    assign ram_word = fwd_hit_q ? fwd_data_q : ram_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        bad_d   = bad_q;
        resp_d  = resp_q;
        unique case (1'b1)
            state_q[IDLE_B]: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                    addr_d  = pc_word;
                    bad_d   = pc_bad(PC, ADDR_WIDTH);
                end
            end
            state_q[WAIT_B]: begin
                if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    resp_d.fault = bad_q;
                    resp_d.instr = bad_q ? INST_NOP
                                         : ram_word;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            state_q[RESP_B]: begin
                if (Inst_Ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            bad_q      <= 1'b0;
            resp_q     <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            bad_q      <= bad_d;
            resp_q     <= resp_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign Inst_Req_Ready = req_ready && rst_n;
    assign Inst_Valid     = state_q[RESP_B];
    assign Instruction    = resp_q.instr;
    assign Inst_Fault     = resp_q.fault;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder: LATENCY=2 instance
// plus a LATENCY=1 instance sharing memory loads.
module tb_inst_mem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W4  = 32'h0050_0093;
    localparam logic [31:0] W0  = 32'h0010_0113;
    localparam logic [31:0] WL  = 32'hDEAD_BEEF;
    localparam logic [31:0] W5O = 32'h1111_1111;
    localparam logic [31:0] W5N = 32'h2222_2222;
    localparam logic [31:0] W8  = 32'h00A0_0113;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC;
    logic        Inst_Ready;
    logic        Load_En;
    logic [9:0]  Load_Addr;
    logic [31:0] Load_Data;

    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [31:0] instruction [2];
    logic        inst_valid  [2];
    logic        fault       [2];

    typedef struct {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    exp_t        sbq [$];
    vec_t        vt  [7];
    logic [31:0] ref_mem [1024];

    int n_chk;
    int n_pass;

    inst_mem_responder #(
        .ADDR_WIDTH(10),
        .LATENCY   (2)
    ) u_dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC            (PC),
        .Inst_Req_Valid(req_valid[0]),
        .Inst_Req_Ready(req_ready[0]),
        .Instruction   (instruction[0]),
        .Inst_Valid    (inst_valid[0]),
        .Inst_Ready    (Inst_Ready),
        .Inst_Fault    (fault[0]),
        .Load_En       (Load_En),
        .Load_Addr     (Load_Addr),
        .Load_Data     (Load_Data)
    );

    inst_mem_responder #(
        .ADDR_WIDTH(10),
        .LATENCY   (1)
    ) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC            (PC),
        .Inst_Req_Valid(req_valid[1]),
        .Inst_Req_Ready(req_ready[1]),
        .Instruction   (instruction[1]),
        .Inst_Valid    (inst_valid[1]),
        .Inst_Ready    (Inst_Ready),
        .Inst_Fault    (fault[1]),
        .Load_En       (Load_En),
        .Load_Addr     (Load_Addr),
        .Load_Data     (Load_Data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic load(
        input int          a,
        input logic [31:0] d
    );
        @(negedge clk);
        Load_En   = 1'b1;
        Load_Addr = 10'(a);
        Load_Data = d;
        ref_mem[a] = d;
        @(negedge clk);
        Load_En = 1'b0;
    endtask

    // Called in the first cycle after acceptance.
    task automatic wait_resp(
        input int d,
        input int lat
    );
        int   c;
        exp_t e;
        c = 0;
        while (!inst_valid[d] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("latency", c, lat);
        e = sbq.pop_front();
        chk("instr", instruction[d], e.instr);
        chk("fault", 32'(fault[d]), 32'(e.fault));
    endtask

    task automatic fetch(
        input int          d,
        input int          lat,
        input logic [31:0] pc,
        input logic [31:0] ei,
        input logic        ef
    );
        @(negedge clk);
        PC           = pc;
        req_valid[d] = 1'b1;
        Inst_Ready   = 1'b1;
        #1;
        chk("req_ready", 32'(req_ready[d]), 32'd1);
        sbq.push_back(exp_t'{ei, ef});
        @(negedge clk);
        req_valid[d] = 1'b0;
        wait_resp(d, lat);
        @(negedge clk);
        chk("valid_drop", 32'(inst_valid[d]), 32'd0);
        chk("ready_again", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        exp_t e;
        n_chk        = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        PC           = '0;
        Inst_Ready   = 1'b0;
        Load_En      = 1'b0;
        Load_Addr    = '0;
        Load_Data    = '0;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        foreach (ref_mem[i]) ref_mem[i] = '0;

        vt[0] = '{32'h0000_0010, W4,  1'b0};
        vt[1] = '{32'h0000_0000, W0,  1'b0};
        vt[2] = '{32'h0000_0FFC, WL,  1'b0};
        vt[3] = '{32'h0000_0012, NOP, 1'b1};
        vt[4] = '{32'h0000_1000, NOP, 1'b1};
        vt[5] = '{32'h0000_0001, NOP, 1'b1};
        vt[6] = '{32'h8000_0010, NOP, 1'b1};

        // Reset state
        #12;
        chk("rst_valid", 32'(inst_valid[0]), 32'd0);
        chk("rst_rdy", 32'(req_ready[0]), 32'd0);
        chk("rst_instr", instruction[0], 32'd0);
        chk("rst_fault", 32'(fault[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load(4, W4);
        load(0, W0);
        load(1023, WL);
        load(5, W5O);

        // Table vectors on LATENCY=2
        for (int i = 0; i < 7; i++) begin
            fetch(0, 2, vt[i].pc,
                  vt[i].instr, vt[i].fault);
        end

        // Backpressure: hold 5 cycles, ignore new request
        @(negedge clk);
        PC           = 32'h10;
        req_valid[0] = 1'b1;
        Inst_Ready   = 1'b0;
        sbq.push_back(exp_t'{W4, 1'b0});
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_resp(0, 2);
        PC           = 32'h0;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(inst_valid[0]), 32'd1);
            chk("bp_instr", instruction[0], W4);
            chk("bp_noacc", 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        Inst_Ready   = 1'b1;
        @(negedge clk);
        chk("bp_done", 32'(inst_valid[0]), 32'd0);
        repeat (4) @(negedge clk);
        chk("bp_noqueue", 32'(inst_valid[0]), 32'd0);

        // Load has priority over acceptance in idle
        @(negedge clk);
        Load_En      = 1'b1;
        Load_Addr    = 10'd8;
        Load_Data    = W8;
        ref_mem[8]   = W8;
        PC           = 32'h20;
        req_valid[0] = 1'b1;
        #1;
        chk("ld_block", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        Load_En = 1'b0;
        #1;
        chk("ld_noacc", 32'(req_ready[0]), 32'd1);
        sbq.push_back(exp_t'{ref_mem[8], 1'b0});
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("ld_acc", 32'(req_ready[0]), 32'd0);
        wait_resp(0, 2);
        @(negedge clk);

        // Read-first: load in the capture cycle
        @(negedge clk);
        PC           = 32'h14;
        req_valid[0] = 1'b1;
        sbq.push_back(exp_t'{ref_mem[5], 1'b0});
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        Load_En   = 1'b1;
        Load_Addr = 10'd5;
        Load_Data = W5N;
        @(negedge clk);
        Load_En    = 1'b0;
        ref_mem[5] = W5N;
        chk("rf_valid", 32'(inst_valid[0]), 32'd1);
        e = sbq.pop_front();
        chk("rf_old", instruction[0], e.instr);
        @(negedge clk);
        fetch(0, 2, 32'h14, W5N, 1'b0);

        // Async reset mid-WAIT
        @(negedge clk);
        PC           = 32'h10;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rw_valid", 32'(inst_valid[0]), 32'd0);
        chk("rw_rdy", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset mid-RESP
        @(negedge clk);
        PC           = 32'h0;
        req_valid[0] = 1'b1;
        Inst_Ready   = 1'b0;
        sbq.push_back(exp_t'{W0, 1'b0});
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_resp(0, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_valid", 32'(inst_valid[0]), 32'd0);
        chk("rr_rdy", 32'(req_ready[0]), 32'd0);
        chk("rr_instr", instruction[0], 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fetch(0, 2, 32'h10, W4, 1'b0);

        // LATENCY=1 sweep
        fetch(1, 1, 32'h10, W4, 1'b0);
        fetch(1, 1, 32'h12, NOP, 1'b1);
        fetch(1, 1, 32'h0FFC, WL, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
